// File: rtl/uart_boot_loader.sv
// Host-command boot engine: parses LOAD/START/DUMP from the UART byte stream and drives
// the memory port, with range checking, checksum reporting and inter-byte timeout.
module uart_boot_loader #(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE = 'h400,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_rx_byte,
  input  logic                    i_rx_valid,
  output logic [7:0]              o_tx_byte,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ack,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic [8*WORD_BYTES-1:0] o_mem_wdata,
  output logic                    o_mem_we,
  output logic                    o_mem_re,
  input  logic                    i_mem_ack,
  input  logic [8*WORD_BYTES-1:0] i_mem_rdata,
  output logic                    o_start,
  output logic [ADDR_W-1:0]       o_start_addr,
  output logic                    o_busy,
  output logic                    o_overrun,
  output logic                    o_timeout
);

  localparam int unsigned WW     = 8 * WORD_BYTES;
  localparam int unsigned RW     = ADDR_W + 4;
  localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CHUNKS = (WORD_BYTES + 3) / 4;
  localparam int unsigned PW     = CHUNKS * 32;
  localparam logic [RW-1:0] LIMIT = RW'(MEM_BASE) + RW'(MEM_WORDS) * RW'(WORD_BYTES);

  typedef enum logic [3:0] {
    StIdle, StLSize, StLAddr, StLCsum, StLData, StLWrite, StStatus,
    StSAddr, StSFire, StDSize, StDAddr, StDRead, StDSend, StDCsum
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       field_q, field_d;
  logic [ADDR_W-1:0] size_q, size_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] words_left_q, words_left_d;
  logic [31:0]       csum_exp_q, csum_exp_d;
  logic [31:0]       csum_acc_q, csum_acc_d;
  logic [WW-1:0]     word_buf_q, word_buf_d;
  logic [7:0]        status_q, status_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic [31:0]       rx_field;
  logic [ADDR_W-1:0] rx_addr;
  logic [RW-1:0]     span_end;
  logic              range_ok;
  logic              last4;
  logic              timed;
  logic              rx_blocked;
  logic              tmo_hit;

  // Wide words fold into the 32-bit checksum as a sum of their 32-bit chunks.
  function automatic logic [31:0] word_sum(input logic [WW-1:0] w);
    logic [PW-1:0] p;
    logic [31:0]   s;
    p = PW'(w);
    s = '0;
    for (int i = 0; i < int'(CHUNKS); i++) s += p[i*32 +: 32];
    return s;
  endfunction

  assign rx_field = {i_rx_byte, field_q};
  assign rx_addr  = ADDR_W'(rx_field);
  assign span_end = RW'(rx_addr) + RW'(size_q) * RW'(WORD_BYTES);
  assign range_ok = (size_q != '0) && ((rx_addr & ADDR_W'(WORD_BYTES - 1)) == '0) &&
                    (rx_addr >= MEM_BASE) && (span_end <= LIMIT);
  assign last4    = (byte_cnt_q == 3'd3);

  assign timed = (state_q == StLSize) || (state_q == StLAddr) || (state_q == StLCsum) ||
                 (state_q == StLData) || (state_q == StSAddr) || (state_q == StDSize) ||
                 (state_q == StDAddr);
  assign rx_blocked = !timed && (state_q != StIdle);
  assign tmo_hit    = timed && !i_rx_valid && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    field_d      = field_q;
    size_d       = size_q;
    cur_addr_d   = cur_addr_q;
    words_left_d = words_left_q;
    csum_exp_d   = csum_exp_q;
    csum_acc_d   = csum_acc_q;
    word_buf_d   = word_buf_q;
    status_d     = status_q;
    overrun_d    = overrun_q;
    timeout_d    = 1'b0;
    start_addr_d = start_addr_q;
    tmo_cnt_d    = (!timed || i_rx_valid || tmo_hit) ? '0 : tmo_cnt_q + TW'(1);

    case (state_q)
      StIdle: begin
        if (i_rx_valid) begin
          byte_cnt_d = '0;
          overrun_d  = 1'b0;
          case (i_rx_byte)
            8'h10:   state_d = StLSize;
            8'h20:   state_d = StSAddr;
            8'h30:   state_d = StDSize;
            default: begin
              status_d = 8'h02;
              state_d  = StStatus;
            end
          endcase
        end
      end
      StLSize, StDSize: begin
        if (i_rx_valid) begin
          field_d    = rx_field[31:8];
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (last4) begin
            size_d     = ADDR_W'(rx_field);
            byte_cnt_d = '0;
            state_d    = (state_q == StLSize) ? StLAddr : StDAddr;
          end
        end
      end
      StLAddr, StDAddr: begin
        if (i_rx_valid) begin
          field_d    = rx_field[31:8];
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (last4) begin
            byte_cnt_d = '0;
            if (!range_ok) begin
              status_d = 8'h02;
              state_d  = StStatus;
            end else begin
              cur_addr_d   = rx_addr;
              words_left_d = size_q;
              csum_acc_d   = '0;
              state_d      = (state_q == StLAddr) ? StLCsum : StDRead;
            end
          end
        end
      end
      StLCsum: begin
        if (i_rx_valid) begin
          field_d    = rx_field[31:8];
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (last4) begin
            csum_exp_d = rx_field;
            byte_cnt_d = '0;
            state_d    = StLData;
          end
        end
      end
      StLData: begin
        if (i_rx_valid) begin
          word_buf_d[{byte_cnt_q, 3'b000} +: 8] = i_rx_byte;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'(WORD_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = StLWrite;
          end
        end
      end
      StLWrite: begin
        if (i_mem_ack) begin
          cur_addr_d   = cur_addr_q + ADDR_W'(WORD_BYTES);
          csum_acc_d   = csum_acc_q + word_sum(word_buf_q);
          words_left_d = words_left_q - ADDR_W'(1);
          if (words_left_q == ADDR_W'(1)) begin
            status_d = (csum_acc_d == csum_exp_q) ? 8'h01 : 8'h00;
            state_d  = StStatus;
          end else begin
            state_d = StLData;
          end
        end
      end
      StStatus: begin
        if (i_tx_ack) state_d = StIdle;
      end
      StSAddr: begin
        if (i_rx_valid) begin
          field_d    = rx_field[31:8];
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (last4) begin
            start_addr_d = rx_addr;
            byte_cnt_d   = '0;
            state_d      = StSFire;
          end
        end
      end
      StSFire: state_d = StIdle;
      StDRead: begin
        if (i_mem_ack) begin
          word_buf_d = i_mem_rdata;
          csum_acc_d = csum_acc_q + word_sum(i_mem_rdata);
          byte_cnt_d = '0;
          state_d    = StDSend;
        end
      end
      StDSend: begin
        if (i_tx_ack) begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'(WORD_BYTES - 1)) begin
            byte_cnt_d = '0;
            if (words_left_q == ADDR_W'(1)) begin
              state_d = StDCsum;
            end else begin
              cur_addr_d   = cur_addr_q + ADDR_W'(WORD_BYTES);
              words_left_d = words_left_q - ADDR_W'(1);
              state_d      = StDRead;
            end
          end
        end
      end
      StDCsum: begin
        if (i_tx_ack) begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (last4) begin
            byte_cnt_d = '0;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (i_rx_valid && rx_blocked) overrun_d = 1'b1;

    // An arriving byte always beats counter expiry, so tmo_hit already excludes it.
    if (tmo_hit) begin
      state_d    = StIdle;
      byte_cnt_d = '0;
      timeout_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      field_q      <= '0;
      size_q       <= '0;
      cur_addr_q   <= '0;
      words_left_q <= '0;
      csum_exp_q   <= '0;
      csum_acc_q   <= '0;
      word_buf_q   <= '0;
      status_q     <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      start_addr_q <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      field_q      <= field_d;
      size_q       <= size_d;
      cur_addr_q   <= cur_addr_d;
      words_left_q <= words_left_d;
      csum_exp_q   <= csum_exp_d;
      csum_acc_q   <= csum_acc_d;
      word_buf_q   <= word_buf_d;
      status_q     <= status_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      start_addr_q <= start_addr_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_byte  = 8'h00;
    case (state_q)
      StStatus: begin
        o_tx_valid = 1'b1;
        o_tx_byte  = status_q;
      end
      StDSend: begin
        o_tx_valid = 1'b1;
        o_tx_byte  = word_buf_q[{byte_cnt_q, 3'b000} +: 8];
      end
      StDCsum: begin
        o_tx_valid = 1'b1;
        o_tx_byte  = csum_acc_q[{byte_cnt_q[1:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign o_mem_addr   = cur_addr_q;
  assign o_mem_wdata  = word_buf_q;
  assign o_mem_we     = (state_q == StLWrite);
  assign o_mem_re     = (state_q == StDRead);
  assign o_start      = (state_q == StSFire);
  assign o_start_addr = start_addr_q;
  assign o_busy       = (state_q != StIdle);
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected TX bytes and memory writes are queued as
// commands are driven and checked as the DUT produces them; memory is a sparse model.
module tb_uart_boot_loader;

  localparam int unsigned TMO = 100;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_rx_byte = '0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  o_tx_byte;
  logic        o_tx_valid;
  logic        i_tx_ack = 1'b0;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_we;
  logic        o_mem_re;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_start;
  logic [31:0] o_start_addr;
  logic        o_busy;
  logic        o_overrun;
  logic        o_timeout;

  uart_boot_loader #(
    .WORD_BYTES(4), .ADDR_W(32), .MEM_BASE(32'h400), .MEM_WORDS(4096), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_byte(i_rx_byte), .i_rx_valid(i_rx_valid),
    .o_tx_byte(o_tx_byte), .o_tx_valid(o_tx_valid), .i_tx_ack(i_tx_ack),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
    .o_mem_re(o_mem_re), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_start(o_start), .o_start_addr(o_start_addr), .o_busy(o_busy),
    .o_overrun(o_overrun), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  tx_exp_q[$];
  logic [63:0] wr_exp_q[$];
  logic [31:0] mem[logic [31:0]];
  logic        tx_stall  = 1'b0;
  logic        mem_stall = 1'b0;
  int          start_cnt = 0;
  int          tmo_cnt   = 0;
  logic [31:0] last_start_addr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responders and monitors act on the falling edge, away from the DUT's sampling edge.
  always @(negedge i_clk) begin
    if (o_start) begin
      start_cnt++;
      last_start_addr = o_start_addr;
    end
    if (o_timeout) tmo_cnt++;

    if (i_tx_ack) begin
      i_tx_ack = 1'b0;
    end else if (o_tx_valid && !tx_stall && !i_rst) begin
      check("tx_pending", 64'(tx_exp_q.size() != 0), 64'd1);
      if (tx_exp_q.size() != 0) check("tx_byte", 64'(o_tx_byte), 64'(tx_exp_q.pop_front()));
      i_tx_ack = 1'b1;
    end

    if (i_mem_ack) begin
      i_mem_ack = 1'b0;
    end else if ((o_mem_we || o_mem_re) && !mem_stall && !i_rst) begin
      check("we_re_excl", 64'(o_mem_we && o_mem_re), 64'd0);
      check("mem_while_tx", 64'(o_tx_valid), 64'd0);
      if (o_mem_we) begin
        check("wr_pending", 64'(wr_exp_q.size() != 0), 64'd1);
        if (wr_exp_q.size() != 0) begin
          logic [63:0] e;
          e = wr_exp_q.pop_front();
          check("wr_addr", 64'(o_mem_addr), 64'(e[63:32]));
          check("wr_data", 64'(o_mem_wdata), 64'(e[31:0]));
        end
        mem[o_mem_addr] = o_mem_wdata;
      end else begin
        i_mem_rdata = mem.exists(o_mem_addr) ? mem[o_mem_addr] : 32'h0;
      end
      i_mem_ack = 1'b1;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_byte  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[i*8 +: 8]);
  endtask

  task automatic load(input logic [31:0] size, input logic [31:0] addr,
                      input logic [31:0] csum);
    send(8'h10);
    send_word(size);
    send_word(addr);
    send_word(csum);
  endtask

  task automatic push_word_le(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(posedge i_clk);
      #1;
      if (!o_busy && tx_exp_q.size() == 0 && wr_exp_q.size() == 0) break;
    end
    check(tag, {62'(tx_exp_q.size() + wr_exp_q.size()), o_busy, 1'b0}, 64'd0);
  endtask

  initial begin
    int s0;
    int n;

    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("reset_outs", {o_busy, o_tx_valid, o_mem_we, o_mem_re, o_start, o_timeout,
                         o_overrun, 57'd0}, 64'd0);

    // LOAD one word, good checksum
    tx_exp_q.push_back(8'h01);
    wr_exp_q.push_back({32'h400, 32'hDEADBEEF});
    load(32'd1, 32'h400, 32'hDEADBEEF);
    send_word(32'hDEADBEEF);
    drain("load1_drain");

    // START
    s0 = start_cnt;
    send(8'h20);
    check("start_busy", 64'(o_busy), 64'd1);
    send_word(32'h400);
    repeat (4) @(negedge i_clk);
    check("start_pulses", 64'(start_cnt - s0), 64'd1);
    check("start_addr", 64'(last_start_addr), 64'h400);
    check("start_addr_hold", 64'(o_start_addr), 64'h400);
    check("start_idle", 64'(o_busy), 64'd0);

    // LOAD two words, bad then good checksum
    tx_exp_q.push_back(8'h00);
    wr_exp_q.push_back({32'h404, 32'h1});
    wr_exp_q.push_back({32'h408, 32'h2});
    load(32'd2, 32'h404, 32'd4);
    send_word(32'd1);
    send_word(32'd2);
    drain("load2_bad_drain");
    tx_exp_q.push_back(8'h01);
    wr_exp_q.push_back({32'h404, 32'h1});
    wr_exp_q.push_back({32'h408, 32'h2});
    load(32'd2, 32'h404, 32'd3);
    send_word(32'd1);
    send_word(32'd2);
    drain("load2_good_drain");

    // Last word of the window is loadable
    tx_exp_q.push_back(8'h01);
    wr_exp_q.push_back({32'h43FC, 32'h7});
    load(32'd1, 32'h43FC, 32'd7);
    send_word(32'd7);
    drain("load_edge_drain");

    // Range failures: reply after the ADDR field, no writes
    tx_exp_q.push_back(8'h02);
    send(8'h10); send_word(32'd1); send_word(32'h0);
    drain("rng_low_drain");
    tx_exp_q.push_back(8'h02);
    send(8'h10); send_word(32'd1); send_word(32'h402);
    drain("rng_align_drain");
    tx_exp_q.push_back(8'h02);
    send(8'h10); send_word(32'd1); send_word(32'h4400);
    drain("rng_high_drain");
    tx_exp_q.push_back(8'h02);
    send(8'h10); send_word(32'd0); send_word(32'h400);
    drain("rng_zero_drain");
    tx_exp_q.push_back(8'h02);
    send(8'h30); send_word(32'd4096); send_word(32'h404);
    drain("rng_dump_drain");

    // Unknown command
    tx_exp_q.push_back(8'h02);
    send(8'h55);
    drain("unknown_drain");

    // DUMP two words
    push_word_le(32'hDEADBEEF);
    push_word_le(32'h1);
    push_word_le(32'hDEADBEF0);
    send(8'h30); send_word(32'd2); send_word(32'h400);
    drain("dump_drain");

    // Timeout after a partial LOAD
    s0 = tmo_cnt;
    send(8'h10);
    send_word(32'd1);
    n = 0;
    while (n < 300) begin
      @(posedge i_clk);
      #1;
      n++;
      if (o_timeout) break;
    end
    check("timeout_window", 64'(n >= int'(TMO) - 1 && n <= int'(TMO) + 1), 64'd1);
    check("timeout_idle", 64'(o_busy), 64'd0);
    repeat (3) @(negedge i_clk);
    check("timeout_pulses", 64'(tmo_cnt - s0), 64'd1);

    // Overrun while STATUS is waiting for its ack
    tx_stall = 1'b1;
    tx_exp_q.push_back(8'h02);
    send(8'h55);
    send(8'h77);
    check("overrun_set", 64'(o_overrun), 64'd1);
    tx_stall = 1'b0;
    drain("overrun_drain");
    check("overrun_sticky", 64'(o_overrun), 64'd1);
    send(8'h20);
    check("overrun_clr", 64'(o_overrun), 64'd0);
    send_word(32'h500);
    repeat (3) @(negedge i_clk);
    check("start2_addr", 64'(o_start_addr), 64'h500);

    // Reset while a write is held
    mem_stall = 1'b1;
    load(32'd1, 32'h400, 32'd5);
    send_word(32'd5);
    n = 0;
    while (n < 50 && !o_mem_we) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("we_held", 64'(o_mem_we), 64'd1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("rst_ctrl", {o_busy, o_tx_valid, o_mem_we, o_mem_re, o_start, o_timeout,
                       o_overrun, 57'd0}, 64'd0);
    check("rst_addr", {o_mem_addr, o_start_addr}, 64'd0);
    check("rst_data", {o_mem_wdata, 24'd0, o_tx_byte}, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    mem_stall = 1'b0;

    tx_exp_q.push_back(8'h02);
    send(8'h66);
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
